// File: rtl/aq_spsram_init_ctrl_pkg.sv
// aq_spsram_init_ctrl_pkg: shared state encoding, default widths and read latency
package aq_spsram_init_ctrl_pkg;
  typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_WE_WIDTH = 64;
`ifdef AQ_SPSRAM_INIT_CTRL_OUT_FLOP_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif
endpackage

// File: rtl/aq_spsram_init_ctrl_if.sv
// aq_spsram_init_ctrl_if: request/response and init handshake bundle
interface aq_spsram_init_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int WE_WIDTH = 64
);
  logic                  init_req;
  logic                  req_vld;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [WE_WIDTH-1:0]   req_wen;
  logic                  req_rdy;
  logic                  rsp_vld;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  init_done;
  modport master (output init_req, req_vld, req_wr, req_addr, req_wdata, req_wen,
                  input req_rdy, rsp_vld, rsp_rdata, init_done);
  modport slave (input init_req, req_vld, req_wr, req_addr, req_wdata, req_wen,
                 output req_rdy, rsp_vld, rsp_rdata, init_done);
endinterface

// File: rtl/aq_f_spsram_param.sv
// aq_f_spsram_param: behavioural single-port array, active-low controls, registered Q held when idle
module aq_f_spsram_param #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int WE_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  CLK,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  GWEN,
  input  logic [WE_WIDTH-1:0]   WEN,
  output logic [DATA_WIDTH-1:0] Q
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int S = DATA_WIDTH / WE_WIDTH;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] w_mask;
  for (genvar i = 0; i < WE_WIDTH; i++) begin : g_mask
    assign w_mask[i*S +: S] = {S{~WEN[i]}};
  end
  always_ff @(posedge CLK)
    if (!CEN) begin
      if (!GWEN) r_mem[A] <= (r_mem[A] & ~w_mask) | (D & w_mask);
      else Q <= r_mem[A];
    end
endmodule

// File: rtl/aq_spsram_init_ctrl.sv
// aq_spsram_init_ctrl: SRAM controller with zero-init sweep; AQ_SPSRAM_INIT_CTRL_OUT_FLOP_EN adds an output register
module aq_spsram_init_ctrl
  import aq_spsram_init_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WE_WIDTH = DEF_WE_WIDTH
) (
  input logic forever_cpuclk,
  input logic cpurst_b,
  aq_spsram_init_ctrl_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  state_t r_state, w_nstate;
  logic [ADDR_WIDTH-1:0] r_cnt, w_ncnt, w_a;
  logic w_init, w_acc, w_rd, w_cen, w_gwen, r_rsp;
  logic [WE_WIDTH-1:0] w_wen;
  logic [DATA_WIDTH-1:0] w_d, w_q;
  always_ff @(posedge forever_cpuclk or negedge cpurst_b)
    if (!cpurst_b) begin
      r_state <= INIT;
      r_cnt <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt <= w_ncnt;
    end
  // counter saturates at LAST so the sweep never wraps
  always_comb begin
    w_nstate = r_state;
    w_ncnt = r_cnt;
    if (w_init) begin
      w_nstate = (r_cnt == LAST) ? READY : INIT;
      w_ncnt = (r_cnt == LAST) ? r_cnt : r_cnt + 1'b1;
    end
    if (bus.init_req) begin
      w_nstate = INIT;
      w_ncnt = '0;
    end
  end
  assign w_init = r_state == INIT;
  assign bus.req_rdy = ~w_init;
  assign bus.init_done = ~w_init;
  assign w_acc = bus.req_vld & ~w_init;
  assign w_rd = w_acc & ~bus.req_wr;
  assign w_cen = ~(w_init | w_acc);
  assign w_gwen = ~w_init & ~bus.req_wr;
  assign w_wen = w_init ? '0 : bus.req_wen;
  assign w_d = w_init ? '0 : bus.req_wdata;
  assign w_a = w_init ? r_cnt : bus.req_addr;
  assign bus.rsp_vld = r_rsp;
  aq_f_spsram_param #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .WE_WIDTH(WE_WIDTH)
  ) u_ram (
    .A(w_a),
    .CEN(w_cen),
    .CLK(forever_cpuclk),
    .D(w_d),
    .GWEN(w_gwen),
    .WEN(w_wen),
    .Q(w_q)
  );
`ifdef AQ_SPSRAM_INIT_CTRL_OUT_FLOP_EN
  logic r_p1;
  logic [DATA_WIDTH-1:0] r_q;
  // init_req kills the read sitting between Q and the output register
  always_ff @(posedge forever_cpuclk or negedge cpurst_b)
    if (!cpurst_b) begin
      r_p1 <= 1'b0;
      r_rsp <= 1'b0;
      r_q <= '0;
    end else begin
      r_p1 <= w_rd;
      r_rsp <= r_p1 & ~bus.init_req;
      if (r_p1 & ~bus.init_req) r_q <= w_q;
    end
  assign bus.rsp_rdata = r_q;
`else
  logic [DATA_WIDTH-1:0] r_hold;
  always_ff @(posedge forever_cpuclk or negedge cpurst_b)
    if (!cpurst_b) begin
      r_rsp <= 1'b0;
      r_hold <= '0;
    end else begin
      r_rsp <= w_rd;
      if (r_rsp) r_hold <= w_q;
    end
  // Q is live in the response cycle; afterwards the captured copy is shown
  assign bus.rsp_rdata = r_rsp ? w_q : r_hold;
`endif
endmodule

// File: tb/tb_aq_spsram_init_ctrl.sv
// tb_aq_spsram_init_ctrl: directed bench with a behavioural memory/latency model checked every cycle
module tb_aq_spsram_init_ctrl;
  import aq_spsram_init_ctrl_pkg::*;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int DEPTH = 1 << AW;
  typedef struct {int due; logic [DW-1:0] data;} exp_t;
  typedef struct {int cyc; logic [DW-1:0] data;} got_t;
  logic clk, rst_n;
  int checks = 0, errors = 0, cyc = 0, m_left = DEPTH, n;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] m_rdata = '0;
  exp_t exp_q[$];
  got_t got_q[$];
  aq_spsram_init_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(DW)) bus();
  aq_spsram_init_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(DW)) dut (
    .forever_cpuclk(clk),
    .cpurst_b(rst_n),
    .bus(bus)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  // model: sweep lasts DEPTH edges after reset/init_req, reads answer RD_LAT cycles later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = DEPTH;
      exp_q.delete();
      m_rdata = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end else begin
      cyc++;
      if (bus.req_vld && m_left == 0) begin
        if (bus.req_wr) mem[bus.req_addr] = (mem[bus.req_addr] & bus.req_wen) | (bus.req_wdata & ~bus.req_wen);
        else exp_q.push_back('{cyc + RD_LAT - 1, mem[bus.req_addr]});
      end
      if (bus.init_req) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) if (RD_LAT == 2 && exp_q[i].due == cyc) exp_q.delete(i);
        m_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      end else if (m_left > 0) m_left--;
    end
  end
  always @(negedge clk) begin
    logic rdy;
    exp_t e;
    rdy = m_left == 0;
    chk("req_rdy", bus.req_rdy, rdy);
    chk("init_done", bus.init_done, rdy);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      m_rdata = e.data;
      chk("rsp_vld", bus.rsp_vld, 1);
      got_q.push_back('{cyc, bus.rsp_rdata});
    end else chk("rsp_vld", bus.rsp_vld, 0);
    chk("rsp_rdata", bus.rsp_rdata, m_rdata);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int a, input logic [DW-1:0] d, input logic [DW-1:0] wen);
    bus.req_vld = 1; bus.req_wr = 1; bus.req_addr = AW'(a); bus.req_wdata = d; bus.req_wen = wen;
    step();
    bus.req_vld = 0; bus.req_wr = 0;
  endtask
  task automatic rd(input int a);
    bus.req_vld = 1; bus.req_wr = 0; bus.req_addr = AW'(a);
    step();
    bus.req_vld = 0;
  endtask
  task automatic rd_chk(input string nm, input int a, input logic [DW-1:0] exp);
    rd(a);
    repeat (RD_LAT - 1) step();
    chk({nm, "_vld"}, bus.rsp_vld, 1);
    chk(nm, bus.rsp_rdata, exp);
  endtask
  task automatic pulse_init();
    bus.init_req = 1;
    step();
    bus.init_req = 0;
  endtask
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!bus.init_done && cnt < 3000) begin
      step();
      cnt++;
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.init_req = 0; bus.req_vld = 0; bus.req_wr = 0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_wen = '1;
    rst_n = 1;
    #1 rst_n = 0;
    #1 chk("rst_rdy", bus.req_rdy, 0);
    chk("rst_done", bus.init_done, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    #21 rst_n = 1;
    wait_done(n);
    chk("init_cycles", n, 1024);
    rd_chk("rd0", 0, 0);
    rd_chk("rd511", 511, 0);
    rd_chk("rd1023", 1023, 0);
    wr('h3A5, 64'hDEADBEEF_CAFEF00D, '0);
    rd_chk("rd3a5", 'h3A5, 64'hDEADBEEF_CAFEF00D);
    wr(5, '1, '0);
    wr(5, '0, {{32{1'b1}}, {32{1'b0}}});
    rd_chk("partial", 5, 64'hFFFF_FFFF_0000_0000);
    wr(5, 64'h0123_4567_89AB_CDEF, '1);
    rd_chk("wen_ones", 5, 64'hFFFF_FFFF_0000_0000);
    for (int i = 0; i < 8; i++) wr(i, DW'(i), '0);
    got_q.delete();
    for (int i = 0; i < 8; i++) rd(i);
    repeat (3) step();
    chk("stream_cnt", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      chk("stream_data", got_q[i].data, i);
      chk("stream_cyc", got_q[i].cyc - got_q[0].cyc, i);
    end
    wr(9, 64'h1234, '0);
    rd_chk("rd9", 9, 64'h1234);
    pulse_init();
    chk("ireq_rdy", bus.req_rdy, 0);
    chk("ireq_done", bus.init_done, 0);
    repeat (100) step();
    chk("ireq_hold", bus.rsp_rdata, 64'h1234);
    pulse_init();
    wait_done(n);
    chk("reinit_cycles", n, 1024);
    rd_chk("rd9_zero", 9, 0);
    wr(7, 64'hA5, '0);
    rd(7);
    rst_n = 0;
    #1 chk("midrd_vld", bus.rsp_vld, 0);
    chk("midrd_rdata", bus.rsp_rdata, 0);
    chk("midrd_done", bus.init_done, 0);
    #10 rst_n = 1;
    repeat (300) step();
    chk("sweep300_done", bus.init_done, 0);
    rst_n = 0;
    #1 chk("sweep300_rdy", bus.req_rdy, 0);
    #10 rst_n = 1;
    wait_done(n);
    chk("rst_sweep_cycles", n, 1024);
    rd_chk("rd7_zero", 7, 0);
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
